axi4_slv_mem: RTL and testbench
===============================

// Module: axi4_slv_mem
// PURPOSE
//  AXI4 slave-side responder: the memory-mapped target that an AXI4 master port
//  (32b addr, 8b ID, 4b LEN/SIZE, 128b data) connects to.
//  Provides a register-array SRAM with independent read and write channels.
//  Supports INCR bursts only and one outstanding transaction per direction.
//  Serves as the bench/system target for master-side blocks.
// PARAMETERS
//  MEM_DEPTH  256  number of 128-bit words; power of 2, >=2
//  ADDR_LSB   4    byte-offset bits per word (16B beat); fixed at 4
// PORTS
//  ACLK     in   1    clock; all logic on rising edge
//  ARESETn  in   1    reset; synchronous, active-low
//  AWADDR   in   32   write burst start byte address
//  AWID     in   8    write transaction ID
//  AWVALID  in   1    write address valid
//  AWREADY  out  1    write address accepted
//  AWSIZE   in   4    log2 bytes per beat; 4 is the only supported value
//  AWLEN    in   4    beats-1 (1..16 beats)
//  ARADDR   in   32   read burst start byte address
//  ARID     in   8    read transaction ID
//  ARVALID  in   1    read address valid
//  ARREADY  out  1    read address accepted
//  ARSIZE   in   4    as AWSIZE
//  ARLEN    in   4    as AWLEN
//  WDATA    in   128  write data
//  WSTRB    in   16   byte enables; WSTRB[i] -> WDATA[8i+7:8i]
//  WLAST    in   1    last write beat
//  WVALID   in   1    write data valid
//  WREADY   out  1    write data accepted
//  BID      out  8    response ID (= latched AWID)
//  BRESP    out  2    00 OKAY, 10 SLVERR
//  BVALID   out  1    write response valid
//  BREADY   in   1    write response accepted
//  RID      out  8    read ID (= latched ARID)
//  RDATA    out  128  read data
//  RRESP    out  2    00 OKAY, 10 SLVERR
//  RLAST    out  1    last read beat
//  RVALID   out  1    read data valid
//  RREADY   in   1    read data accepted
// BEHAVIOUR
//  Reset (ARESETn=0 at a clock edge): all outputs 0, both FSMs to IDLE,
//   error flags cleared. Memory contents not reset. Reset mid-burst abandons
//   the burst: no B or remaining R beats are issued.
//   AWREADY/ARREADY are registered: 0 while in reset, 1 on the first cycle
//   after release.
//  Word index = addr[ADDR_LSB+:log2(MEM_DEPTH)]. A beat is out of range if
//   addr >= MEM_DEPTH*16. Low addr bits [3:0] are ignored (aligned beats).
//  Beat n addr = start + 16*n. No wrap. The 4KB boundary is not checked.
//   Out-of-range beats are errors.
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   W_IDLE: AWREADY=1, WREADY=0. On AWVALID&&AWREADY, latch addr/ID/LEN.
//    Set err if AWSIZE!=4. Clear beat cnt. Next: W_DATA with AWREADY=0.
//   W_DATA: WREADY=1. Each WVALID&&WREADY beat writes the enabled bytes,
//    unless the beat is out of range or err is set; such a beat is dropped
//    and sets err.
//    err also set if WLAST != (cnt==LEN). The burst ends when cnt==LEN,
//     regardless of WLAST. cnt++ per beat. Next: W_RESP, WREADY=0.
//   W_RESP: BVALID=1, BID=ID, BRESP=err?10:00. Hold until BREADY.
//    BVALID&&BREADY -> W_IDLE, with AWREADY=1 the next cycle.
//  Read FSM R_IDLE -> R_DATA:
//   R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ID/LEN and set err if
//    ARSIZE!=4. Register beat-0 data into RDATA; next cycle R_DATA, RVALID=1.
//    Latency: ARVALID&&ARREADY at cycle t -> RVALID at t+1.
//   R_DATA: RVALID=1, RID=ID, RLAST=(cnt==LEN).
//    RRESP=10 if the beat is out of range or err is set; RDATA=0 for those
//    beats.
//    RDATA/RRESP/RLAST are held stable while RVALID&&!RREADY.
//    On handshake with !RLAST: load the next beat the same cycle, so RVALID
//     stays 1 and back-to-back beats run at 1 beat/cycle.
//    On handshake with RLAST: go to R_IDLE, RVALID=0, ARREADY=1 next cycle.
//  Channels are independent. A write and a read may be active simultaneously.
//   Write/read collision on the same word in one cycle: the read loads the
//   old data, and the write takes effect the next cycle.
//  Handshake rules: outputs never depend combinationally on inputs. Once
//   asserted, VALID is held until its handshake completes.
// TESTING
//  1 Reset, then AW addr=0x100 LEN=3 SIZE=4 ID=0x5A, 4 W beats with
//    WSTRB=FFFF and WLAST on beat 3 -> BVALID, BID=5A, BRESP=00.
//  2 AR addr=0x100 LEN=3 ID=0x21, RREADY=1 -> RVALID at t+1, 4 consecutive
//    beats, matching data, RLAST on beat 3, RRESP=00.
//  3 WSTRB=0x000F write of 0xFF..FF over known data -> a read shows only
//    bytes 0-3 changed. RREADY toggled 1-0-1 -> RDATA held stable while stalled.
//  4 AW addr=MEM_DEPTH*16-16 LEN=1 -> beat 0 written, beat 1 dropped,
//    BRESP=10. AR of the same range -> beat 0 RRESP=00, beat 1 RRESP=10
//    with RDATA=0.
//  5 AWSIZE=2 or WLAST on beat 0 of a LEN=1 burst -> no memory change,
//    BRESP=10. BREADY held low 5 cycles -> BVALID stays 1, AWREADY stays 0.
//  6 ARESETn low mid-read (beat 1 of 4) -> outputs 0 during reset, no further
//    R beats. Next AR after release -> served normally.

Source files
------------

// File: rtl/axi4_slv_mem.sv
// AXI4 slave memory target: 128-bit register-array SRAM behind independent
// write (AW/W/B) and read (AR/R) channels. INCR bursts only, one outstanding
// transaction per direction. All handshake outputs are registered.
module axi4_slv_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_LSB  = 4
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    // write address channel
    input  logic [31:0]  AWADDR,
    input  logic [7:0]   AWID,
    input  logic         AWVALID,
    output logic         AWREADY,
    input  logic [3:0]   AWSIZE,
    input  logic [3:0]   AWLEN,
    // read address channel
    input  logic [31:0]  ARADDR,
    input  logic [7:0]   ARID,
    input  logic         ARVALID,
    output logic         ARREADY,
    input  logic [3:0]   ARSIZE,
    input  logic [3:0]   ARLEN,
    // write data channel
    input  logic [127:0] WDATA,
    input  logic [15:0]  WSTRB,
    input  logic         WLAST,
    input  logic         WVALID,
    output logic         WREADY,
    // write response channel
    output logic [7:0]   BID,
    output logic [1:0]   BRESP,
    output logic         BVALID,
    input  logic         BREADY,
    // read data channel
    output logic [7:0]   RID,
    output logic [127:0] RDATA,
    output logic [1:0]   RRESP,
    output logic         RLAST,
    output logic         RVALID,
    input  logic         RREADY
);

    localparam int          IDX_W      = $clog2(MEM_DEPTH);
    // Addresses are tracked with one extra bit so a burst running past the
    // top of the 32-bit space is still seen as out of range instead of wrapping.
    localparam logic [32:0] MEM_BYTES  = 33'(MEM_DEPTH) << ADDR_LSB;
    localparam logic [32:0] BEAT_BYTES = 33'(1) << ADDR_LSB;
    localparam logic [3:0]  SIZE_OK    = 4'(ADDR_LSB);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [127:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t          w_state, w_next;
    logic [32:0]       w_addr;      // address of the current beat
    logic [7:0]        w_id;
    logic [3:0]        w_len;
    logic [3:0]        w_cnt;
    logic              w_err;       // sticky burst error, reported on B

    logic              aw_fire, w_fire, b_fire;
    logic              w_last_beat, w_oor, w_drop, w_en;
    logic [IDX_W-1:0]  w_idx;

    assign aw_fire     = AWVALID && AWREADY;
    assign w_fire      = WVALID && WREADY;
    assign b_fire      = BVALID && BREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign w_oor       = (w_addr >= MEM_BYTES);
    // A beat is discarded if it is out of range, the burst is already bad,
    // or WLAST disagrees with the beat count; the mismatching beat itself is
    // not written.
    assign w_drop      = w_oor || w_err || (WLAST != w_last_beat);
    assign w_en        = w_fire && !w_drop;
    assign w_idx       = w_addr[ADDR_LSB +: IDX_W];

    // Write FSM next-state decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, otherwise a path
        // that leaves it unassigned infers a latch.
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_fire)                w_next = W_DATA;
            W_DATA:  if (w_fire && w_last_beat)  w_next = W_RESP;
            W_RESP:  if (b_fire)                 w_next = W_IDLE;
            default:                             w_next = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        // NOTE: clocked state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write burst bookkeeping and registered AW/W/B outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            // Ready/valid follow the state being entered, so they are clean
            // registers that never depend combinationally on inputs.
            AWREADY <= (w_next == W_IDLE);
            WREADY  <= (w_next == W_DATA);
            BVALID  <= (w_next == W_RESP);
            if (aw_fire) begin
                w_addr <= {1'b0, AWADDR};
                w_id   <= AWID;
                w_len  <= AWLEN;
                w_cnt  <= '0;
                w_err  <= (AWSIZE != SIZE_OK);
            end
            if (w_fire) begin
                w_addr <= w_addr + BEAT_BYTES;
                w_cnt  <= w_cnt + 4'd1;
                if (w_drop) w_err <= 1'b1;
                if (w_last_beat) begin
                    BID   <= w_id;
                    BRESP <= w_drop ? RESP_SLV : RESP_OKAY;
                end
            end
        end
    end

    // Byte-enabled memory write port.
    always_ff @(posedge ACLK) begin
        // NOTE: the array has no reset; contents survive ARESETn and map onto
        // plain storage without a reset network.
        if (w_en) begin
            for (int i = 0; i < 16; i++) begin
                if (WSTRB[i]) mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t          r_state, r_next;
    logic [32:0]       r_addr;      // address of the beat currently on R
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic              r_err;       // ARSIZE error, applies to whole burst

    logic              ar_fire, r_fire;
    logic              ld_en, ld_err, ld_bad;
    logic [32:0]       ld_addr;
    logic [3:0]        ld_cnt, ld_len;
    logic [IDX_W-1:0]  ld_idx;

    assign ar_fire = ARVALID && ARREADY;
    assign r_fire  = RVALID && RREADY;
    assign ld_bad  = (ld_addr >= MEM_BYTES) || ld_err;
    assign ld_idx  = ld_addr[ADDR_LSB +: IDX_W];

    // Read FSM next-state and beat-load selection (first beat or next beat).
    always_comb begin
        r_next  = r_state;
        ld_en   = 1'b0;
        ld_addr = r_addr;
        ld_err  = r_err;
        ld_cnt  = r_cnt;
        ld_len  = r_len;
        unique case (r_state)
            R_IDLE: begin
                if (ar_fire) begin
                    r_next  = R_DATA;
                    ld_en   = 1'b1;
                    ld_addr = {1'b0, ARADDR};
                    ld_err  = (ARSIZE != SIZE_OK);
                    ld_cnt  = '0;
                    ld_len  = ARLEN;
                end
            end
            R_DATA: begin
                if (r_fire) begin
                    if (RLAST) begin
                        r_next = R_IDLE;
                    end else begin
                        // Next beat is fetched in the handshake cycle so
                        // RVALID stays high and beats stream at one per clock.
                        ld_en   = 1'b1;
                        ld_addr = r_addr + BEAT_BYTES;
                        ld_cnt  = r_cnt + 4'd1;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read beat registers and registered AR/R outputs. The memory read sees
    // pre-edge contents, so a same-cycle write to the word lands afterwards.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            ARREADY <= (r_next == R_IDLE);
            RVALID  <= (r_next == R_DATA);
            if (ar_fire) RID <= ARID;
            if (ld_en) begin
                r_addr <= ld_addr;
                r_cnt  <= ld_cnt;
                r_len  <= ld_len;
                r_err  <= ld_err;
                RDATA  <= ld_bad ? '0 : mem[ld_idx];
                RRESP  <= ld_bad ? RESP_SLV : RESP_OKAY;
                RLAST  <= (ld_cnt == ld_len);
            end else if (r_fire) begin
                RLAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_slv_mem.sv
// Directed self-checking bench for axi4_slv_mem: bursts, strobes, range and
// protocol errors, B/R back-pressure and mid-burst reset.
module tb_axi4_slv_mem;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [31:0]  AWADDR;
    logic [7:0]   AWID;
    logic         AWVALID;
    logic         AWREADY;
    logic [3:0]   AWSIZE;
    logic [3:0]   AWLEN;
    logic [31:0]  ARADDR;
    logic [7:0]   ARID;
    logic         ARVALID;
    logic         ARREADY;
    logic [3:0]   ARSIZE;
    logic [3:0]   ARLEN;
    logic [127:0] WDATA;
    logic [15:0]  WSTRB;
    logic         WLAST;
    logic         WVALID;
    logic         WREADY;
    logic [7:0]   BID;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [7:0]   RID;
    logic [127:0] RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;

    int checks = 0;
    int errors = 0;

    logic [127:0] base  [4];   // data written by the first burst
    logic [127:0] wd    [16];  // W beat payloads for the next burst
    logic [127:0] exp_d [16];  // expected RDATA per beat
    logic [1:0]   exp_r [16];  // expected RRESP per beat
    logic [127:0] d1m;         // word 0x110 after the strobed write

    axi4_slv_mem #(.MEM_DEPTH(256), .ADDR_LSB(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .AWSIZE(AWSIZE), .AWLEN(AWLEN),
        .ARADDR(ARADDR), .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .ARSIZE(ARSIZE), .ARLEN(ARLEN),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] id,
                           input logic [3:0] len, input logic [3:0] size);
        bit done = 1'b0;
        AWADDR = addr; AWID = id; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (AWREADY === 1'b1) done = 1'b1;
            tick();
        end
        AWVALID = 1'b0;
        check("aw_handshake", 128'(done), 128'(1));
    endtask

    task automatic send_w(input int n, input logic [15:0] strb, input logic [15:0] last_mask);
        for (int b = 0; b < n; b++) begin
            bit done = 1'b0;
            WDATA = wd[b]; WSTRB = strb; WLAST = last_mask[b]; WVALID = 1'b1;
            for (int i = 0; i < 20 && !done; i++) begin
                if (WREADY === 1'b1) done = 1'b1;
                tick();
            end
            check($sformatf("w_handshake_b%0d", b), 128'(done), 128'(1));
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic recv_b(input logic [7:0] id, input logic [1:0] resp, input int stall);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (BVALID === 1'b1) seen = 1'b1;
            else tick();
        end
        check("b_valid", 128'(seen), 128'(1));
        check("bid", 128'(BID), 128'(id));
        check("bresp", 128'(BRESP), 128'(resp));
        for (int s = 0; s < stall; s++) begin
            tick();
            check($sformatf("b_hold_valid_c%0d", s), 128'(BVALID), 128'(1));
            check($sformatf("b_hold_awready_c%0d", s), 128'(AWREADY), 128'(0));
            check($sformatf("b_hold_resp_c%0d", s), 128'(BRESP), 128'(resp));
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("b_released", 128'(BVALID), 128'(0));
        check("awready_back", 128'(AWREADY), 128'(1));
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] id,
                           input logic [3:0] len, input logic [3:0] size);
        bit done = 1'b0;
        ARADDR = addr; ARID = id; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ARREADY === 1'b1) done = 1'b1;
            tick();
        end
        ARVALID = 1'b0;
        check("ar_handshake", 128'(done), 128'(1));
        // one cycle after the AR handshake the first beat must be valid
        check("r_latency", 128'(RVALID), 128'(1));
    endtask

    // Full read burst against exp_d/exp_r; beat stall_at is held off for two
    // cycles with RREADY low (stall_at < 0 means no stall).
    task automatic do_read(input logic [31:0] addr, input logic [7:0] id,
                           input logic [3:0] len, input logic [3:0] size, input int stall_at);
        RREADY = 1'b1;
        send_ar(addr, id, len, size);
        for (int b = 0; b <= int'(len); b++) begin
            check($sformatf("r_valid_b%0d", b), 128'(RVALID), 128'(1));
            check($sformatf("rid_b%0d", b), 128'(RID), 128'(id));
            check($sformatf("rdata_b%0d", b), RDATA, exp_d[b]);
            check($sformatf("rresp_b%0d", b), 128'(RRESP), 128'(exp_r[b]));
            check($sformatf("rlast_b%0d", b), 128'(RLAST), 128'(b == int'(len)));
            if (b == stall_at) begin
                RREADY = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    check($sformatf("stall_valid_c%0d", s), 128'(RVALID), 128'(1));
                    check($sformatf("stall_rdata_c%0d", s), RDATA, exp_d[b]);
                    check($sformatf("stall_rlast_c%0d", s), 128'(RLAST), 128'(b == int'(len)));
                end
                RREADY = 1'b1;
            end
            tick();
        end
        check("r_done_valid", 128'(RVALID), 128'(0));
        check("r_done_arready", 128'(ARREADY), 128'(1));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"},
              128'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RRESP, RLAST, RVALID}),
              128'(0));
        check({tag, "_rdata"}, RDATA, 128'(0));
    endtask

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWID = '0; AWVALID = 1'b0; AWSIZE = '0; AWLEN = '0;
        ARADDR = '0; ARID = '0; ARVALID = 1'b0; ARSIZE = '0; ARLEN = '0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < 4; i++) base[i] = {4{32'hA5A5_0000 | 32'(i)}} ^ {32'h0, 32'h0, 32'h0, 32'h1357_9BDF};
        for (int i = 0; i < 16; i++) begin
            wd[i] = '0; exp_d[i] = '0; exp_r[i] = 2'b00;
        end

        // Reset: everything low, ready registers rise one cycle after release
        repeat (3) tick();
        check_outputs_zero("reset");
        ARESETn = 1'b1;
        tick();
        check("awready_after_reset", 128'(AWREADY), 128'(1));
        check("arready_after_reset", 128'(ARREADY), 128'(1));

        // 1: 4-beat write at 0x100
        for (int i = 0; i < 4; i++) wd[i] = base[i];
        send_aw(32'h100, 8'h5A, 4'd3, 4'd4);
        send_w(4, 16'hFFFF, 16'h0008);
        recv_b(8'h5A, 2'b00, 0);

        // 2: read it back, back-to-back beats
        for (int i = 0; i < 4; i++) begin exp_d[i] = base[i]; exp_r[i] = 2'b00; end
        do_read(32'h100, 8'h21, 4'd3, 4'd4, -1);

        // 3: strobe only bytes 0-3 of word 0x110, read with RREADY 1-0-1
        wd[0] = '1;
        send_aw(32'h110, 8'h33, 4'd0, 4'd4);
        send_w(1, 16'h000F, 16'h0001);
        recv_b(8'h33, 2'b00, 0);
        d1m = {base[1][127:32], 32'hFFFF_FFFF};
        exp_d[0] = base[0]; exp_d[1] = d1m; exp_d[2] = base[2];
        exp_r[0] = 2'b00;   exp_r[1] = 2'b00; exp_r[2] = 2'b00;
        do_read(32'h100, 8'h44, 4'd2, 4'd4, 1);

        // 4: burst crossing the top of memory: beat 0 lands, beat 1 dropped
        wd[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        wd[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        send_aw(32'h0000_0FF0, 8'h66, 4'd1, 4'd4);
        send_w(2, 16'hFFFF, 16'h0002);
        recv_b(8'h66, 2'b10, 0);
        exp_d[0] = wd[0]; exp_r[0] = 2'b00;
        exp_d[1] = '0;    exp_r[1] = 2'b10;
        do_read(32'h0000_0FF0, 8'h77, 4'd1, 4'd4, -1);

        // 5a: bad AWSIZE, B held off five cycles
        wd[0] = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        send_aw(32'h100, 8'h88, 4'd0, 4'd2);
        send_w(1, 16'hFFFF, 16'h0001);
        recv_b(8'h88, 2'b10, 5);

        // 5b: early WLAST on beat 0 of a 2-beat burst
        wd[0] = 128'hCAFE_0000_CAFE_0000_CAFE_0000_CAFE_0000;
        wd[1] = 128'hCAFE_1111_CAFE_1111_CAFE_1111_CAFE_1111;
        send_aw(32'h120, 8'h99, 4'd1, 4'd4);
        send_w(2, 16'hFFFF, 16'h0001);
        recv_b(8'h99, 2'b10, 0);

        // neither erroneous write touched memory
        exp_d[0] = base[0]; exp_d[1] = d1m; exp_d[2] = base[2];
        exp_r[0] = 2'b00;   exp_r[1] = 2'b00; exp_r[2] = 2'b00;
        do_read(32'h100, 8'h12, 4'd2, 4'd4, -1);

        // bad ARSIZE: data suppressed, SLVERR
        exp_d[0] = '0; exp_r[0] = 2'b10;
        do_read(32'h100, 8'h13, 4'd0, 4'd2, -1);

        // 6: reset during beat 1 of a 4-beat read
        RREADY = 1'b1;
        send_ar(32'h100, 8'h55, 4'd3, 4'd4);
        check("mid_rdata_b0", RDATA, base[0]);
        tick();
        check("mid_rdata_b1", RDATA, d1m);
        check("mid_valid_b1", 128'(RVALID), 128'(1));
        RREADY = 1'b0;
        ARESETn = 1'b0;
        tick();
        check_outputs_zero("midreset_c0");
        tick();
        check_outputs_zero("midreset_c1");
        ARESETn = 1'b1;
        RREADY = 1'b1;
        tick();
        check("post_reset_arready", 128'(ARREADY), 128'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_no_r_c%0d", i), 128'(RVALID), 128'(0));
        end
        exp_d[0] = base[0]; exp_d[1] = d1m; exp_d[2] = base[2]; exp_d[3] = base[3];
        for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
        do_read(32'h100, 8'h34, 4'd3, 4'd4, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
